free_list: RTL and testbench
============================

Name: free_list

Overview:
- Physical-register free list for the R10K rename stage.
- Hands out one free physical tag (T_new) per dispatch and accepts one freed tag (T_old) per retire.
- Exports its next-state contents every cycle to free_list_check, which snapshots them at branch dispatch.
- On branch mispredict it reloads from that checkpoint.
- Storage is a shift-style list: entry 0 is the head; tail is the occupancy count.

Parameters:
- FL_SIZE, 32: number of list entries (physical regs minus architectural regs).
- NUM_GEN_REG, 32: architectural register count; also the initial occupancy.
- PR_W, 6: PHYS_REG width, from $clog2(NUM_GEN_REG+FL_SIZE).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- dispatch_en  in  1  pop request (rename allocating T_new).
- retire_en  in  1  push request.
- T_old_in  in  PR_W  tag freed at retire.
- restore_en  in  1  mispredict recovery; load the checkpoint.
- free_list_restore  in  FL_SIZE*PR_W  checkpoint contents from free_list_check.
- tail_restore  in  $clog2(FL_SIZE)+1  checkpoint occupancy.
- T_new_out  out  PR_W  head entry, free_list[0].
- T_new_valid  out  1  tail != 0.
- free_list_chkpt  out  FL_SIZE*PR_W  next-state contents, combinational, to free_list_check.
- tail_chkpt  out  $clog2(FL_SIZE)+1  next-state tail, combinational.
- empty  out  1  tail == 0, registered-state.
- full  out  1  tail == FL_SIZE, registered-state.

Behaviour:
- Reset (reset==0, async):
  - free_list[i] = NUM_GEN_REG+i for i < NUM_GEN_REG; remaining entries = 0.
  - tail = NUM_GEN_REG.
  - Resulting outputs: T_new_out = NUM_GEN_REG, T_new_valid = 1, empty = 0, full = (NUM_GEN_REG==FL_SIZE).
- State is free_list[FL_SIZE] plus tail. All updates occur on posedge clock; the next-state logic is a single always_comb.
- Pop is effective when dispatch_en && tail != 0:
  - entries shift down by one (entry i takes entry i+1); top slot cleared to 0.
  - tail decrements by 1.
  - T_new_out is valid in the same cycle as the request (zero-latency read of the head).
- Push is effective when retire_en && tail != FL_SIZE: T_old_in is written at index tail; tail increments by 1.
- Push and pop in the same cycle:
  - shift, then write T_old_in at index tail-1; tail unchanged.
  - If tail == 0, only the push applies (no bypass: T_old_in is not forwarded to T_new_out).
  - If tail == FL_SIZE, both apply (the pop makes room).
- Pop when empty, or push when full, is ignored with no state change. Both are illegal upstream; the bench asserts they never occur in normal traffic.
- Restore (restore_en == 1) has highest priority:
  - next list = free_list_restore; next tail = tail_restore.
  - dispatch_en is ignored that cycle (the dispatching instruction is squashed).
  - retire_en is still honoured: T_old_in is appended at index tail_restore and tail becomes tail_restore+1, because retirement is older than the branch and its free must not be lost.
- Restore mid-reset: reset dominates.
- tail_restore > FL_SIZE is illegal; the bench asserts against it.
- free_list_chkpt/tail_chkpt always equal the values that will be registered at the next edge. A checkpoint taken in the same cycle as a pop therefore already excludes the popped tag.
- Tag 0 is never a legal free-list entry after reset. Empty slots read as 0.

Decomposition:
- Shared in sys_defs.vh:
  - PHYS_REG typedef.
  - `FL_SIZE, `NUM_GEN_REG.
  - FL_TAIL width macro, $clog2(`FL_SIZE)+1.
- No sub-module. Shift and append are generated loops in one always_comb.
- Instantiated next to free_list_check: free_list_chkpt/tail_chkpt drive its free_list_in/tail_in; its outputs drive free_list_restore/tail_restore.

Test Plan:
- Reset, then release → tail=32, T_new_out=32, T_new_valid=1; entry 31 = 63.
- 3 consecutive pops → T_new_out sequence 32, 33, 34; tail=29; free_list[0]=35.
- Pop+push same cycle, T_old_in=5, tail=29 → tail stays 29; free_list[28]=5; head advances by one.
- Drain to empty, then pop+push with T_old_in=7 → tail=1, T_new_out=7 next cycle; T_new_valid low during the drained cycle.
- Take checkpoint (observe tail_chkpt=30), pop 4, assert restore_en with retire_en and T_old_in=9 → tail=31; list equals checkpoint contents with 9 at index 30.
- Assert reset low mid-burst of pops/pushes → state returns to reset image immediately (asynchronously), without waiting for a clock edge.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared sizing and types for the rename-stage physical-register free list.
package free_list_pkg;

    localparam int FL_SIZE     = 32;
    localparam int NUM_GEN_REG = 32;
    localparam int PR_W        = $clog2(NUM_GEN_REG + FL_SIZE);
    localparam int TAIL_W      = $clog2(FL_SIZE) + 1;
    localparam int LIST_W      = FL_SIZE * PR_W;

    typedef logic [PR_W-1:0]   phys_reg_t;
    typedef logic [TAIL_W-1:0] fl_tail_t;

endpackage

// File: rtl/free_list.sv
// Physical-register free list: head at entry 0, tail is the occupancy.
// One pop per dispatch and one push per retire each cycle. Mispredict
// recovery reloads a checkpoint and still keeps the retiring free.
module free_list
    import free_list_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              dispatch_en,
    input  logic              retire_en,
    input  logic [PR_W-1:0]   T_old_in,
    input  logic              restore_en,
    input  logic [LIST_W-1:0] free_list_restore,
    input  logic [TAIL_W-1:0] tail_restore,
    output logic [PR_W-1:0]   T_new_out,
    output logic              T_new_valid,
    output logic [LIST_W-1:0] free_list_chkpt,
    output logic [TAIL_W-1:0] tail_chkpt,
    output logic              empty,
    output logic              full
);

    phys_reg_t list_q [FL_SIZE];
    phys_reg_t list_d [FL_SIZE];
    fl_tail_t  tail_q;
    fl_tail_t  tail_d;

    logic      do_pop;
    logic      do_push;
    fl_tail_t  wr_idx;

    // Next-state: restore beats dispatch, retire is always honoured when there is room.
    always_comb begin
        list_d  = list_q;
        tail_d  = tail_q;
        do_pop  = 1'b0;
        do_push = 1'b0;
        wr_idx  = tail_q;

        if (restore_en) begin
            for (int i = 0; i < FL_SIZE; i++) begin
                list_d[i] = free_list_restore[i*PR_W +: PR_W];
            end
            tail_d  = tail_restore;
            do_push = retire_en && (tail_restore != fl_tail_t'(FL_SIZE));
            wr_idx  = tail_restore;
            if (do_push) begin
                tail_d = tail_restore + fl_tail_t'(1);
            end
        end else begin
            do_pop  = dispatch_en && (tail_q != '0);
            // A pop in the same cycle frees a slot even when the list is full.
            do_push = retire_en && ((tail_q != fl_tail_t'(FL_SIZE)) || do_pop);

            if (do_pop) begin
                for (int i = 0; i < FL_SIZE - 1; i++) begin
                    list_d[i] = list_q[i+1];
                end
                list_d[FL_SIZE-1] = '0;
            end

            if (do_pop && do_push) begin
                wr_idx = tail_q - fl_tail_t'(1);
            end else if (do_pop) begin
                tail_d = tail_q - fl_tail_t'(1);
            end else if (do_push) begin
                tail_d = tail_q + fl_tail_t'(1);
            end
        end

        if (do_push) begin
            for (int i = 0; i < FL_SIZE; i++) begin
                if (fl_tail_t'(i) == wr_idx) begin
                    list_d[i] = T_old_in;
                end
            end
        end
    end

    // State register; reset loads tags NUM_GEN_REG.. into the low entries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FL_SIZE; i++) begin
                list_q[i] <= (i < NUM_GEN_REG) ? phys_reg_t'(NUM_GEN_REG + i) : '0;
            end
            tail_q <= fl_tail_t'(NUM_GEN_REG);
        end else begin
            list_q <= list_d;
            tail_q <= tail_d;
        end
    end

    // Checkpoint export is the next-state image, so a same-cycle pop is already excluded.
    always_comb begin
        free_list_chkpt = '0;
        for (int i = 0; i < FL_SIZE; i++) begin
            free_list_chkpt[i*PR_W +: PR_W] = list_d[i];
        end
        tail_chkpt = tail_d;
    end

    assign T_new_out   = list_q[0];
    assign T_new_valid = (tail_q != '0);
    assign empty       = (tail_q == '0);
    assign full        = (tail_q == fl_tail_t'(FL_SIZE));

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset image, pops, pop+push, drain,
// checkpoint/restore with retire, and asynchronous reset mid-traffic.
module tb_free_list;
    import free_list_pkg::*;

    logic              clock;
    logic              reset;
    logic              dispatch_en;
    logic              retire_en;
    logic [PR_W-1:0]   T_old_in;
    logic              restore_en;
    logic [LIST_W-1:0] free_list_restore;
    logic [TAIL_W-1:0] tail_restore;
    logic [PR_W-1:0]   T_new_out;
    logic              T_new_valid;
    logic [LIST_W-1:0] free_list_chkpt;
    logic [TAIL_W-1:0] tail_chkpt;
    logic              empty;
    logic              full;

    int vectors;
    int miscompares;

    logic [PR_W-1:0]   exp_l [FL_SIZE];
    logic [LIST_W-1:0] ckpt_vec;

    free_list dut (
        .clock             (clock),
        .reset             (reset),
        .dispatch_en       (dispatch_en),
        .retire_en         (retire_en),
        .T_old_in          (T_old_in),
        .restore_en        (restore_en),
        .free_list_restore (free_list_restore),
        .tail_restore      (tail_restore),
        .T_new_out         (T_new_out),
        .T_new_valid       (T_new_valid),
        .free_list_chkpt   (free_list_chkpt),
        .tail_chkpt        (tail_chkpt),
        .empty             (empty),
        .full              (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [LIST_W-1:0] obs, input logic [LIST_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [LIST_W-1:0] pack_exp();
        logic [LIST_W-1:0] v;
        v = '0;
        for (int i = 0; i < FL_SIZE; i++) v[i*PR_W +: PR_W] = exp_l[i];
        return v;
    endfunction

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        dispatch_en = 1'b0;
        retire_en = 1'b0;
        T_old_in = '0;
        restore_en = 1'b0;
        free_list_restore = '0;
        tail_restore = '0;

        // Asynchronous reset before any clock edge
        #2 reset = 1'b0;
        #1;
        chk("rst_head", T_new_out, 32);
        chk("rst_valid", T_new_valid, 1);
        chk("rst_empty", empty, 0);
        chk("rst_full", full, 1);
        chk("rst_tail", tail_chkpt, 32);
        #9 reset = 1'b1;
        tick();

        for (int i = 0; i < FL_SIZE; i++) exp_l[i] = PR_W'(32 + i);
        chk("rst_image", free_list_chkpt, pack_exp());
        chk("rst_entry31", free_list_chkpt[31*PR_W +: PR_W], 63);

        // Push while full is dropped
        retire_en = 1'b1; T_old_in = 6'd2;
        #1;
        chk("full_push_tail", tail_chkpt, 32);
        chk("full_push_list", free_list_chkpt, pack_exp());
        retire_en = 1'b0;

        // Three pops, head visible in the request cycle
        dispatch_en = 1'b1;
        #1;
        chk("pop0_head", T_new_out, 32);
        chk("pop0_tail_chkpt", tail_chkpt, 31);
        tick();
        chk("pop1_head", T_new_out, 33);
        tick();
        chk("pop2_head", T_new_out, 34);
        tick();
        dispatch_en = 1'b0;
        #1;
        chk("pop3_tail", tail_chkpt, 29);
        chk("pop3_head", T_new_out, 35);

        // Simultaneous pop and push at tail 29
        dispatch_en = 1'b1; retire_en = 1'b1; T_old_in = 6'd5;
        #1;
        chk("pp_tail", tail_chkpt, 29);
        chk("pp_entry28", free_list_chkpt[28*PR_W +: PR_W], 5);
        tick();
        dispatch_en = 1'b0; retire_en = 1'b0;
        #1;
        chk("pp_head", T_new_out, 36);
        chk("pp_tail_after", tail_chkpt, 29);

        // Drain: 36..63 then 5
        dispatch_en = 1'b1;
        for (int k = 0; k < 29; k++) begin
            chk("drain_head", T_new_out, (k < 28) ? 36 + k : 5);
            tick();
        end
        chk("drained_valid", T_new_valid, 0);
        chk("drained_empty", empty, 1);
        chk("drained_pop_ignored", tail_chkpt, 0);

        // Pop+push on empty: push only, no bypass
        retire_en = 1'b1; T_old_in = 6'd7;
        #1;
        chk("empty_pp_tail", tail_chkpt, 1);
        chk("empty_pp_nobypass", T_new_out, 0);
        tick();
        dispatch_en = 1'b0; retire_en = 1'b0;
        #1;
        chk("empty_pp_head", T_new_out, 7);
        chk("empty_pp_valid", T_new_valid, 1);

        // Fill with 10..39 at entries 1..30
        retire_en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            T_old_in = PR_W'(10 + k);
            tick();
        end
        retire_en = 1'b0;

        // Checkpoint taken in a pop cycle excludes the popped tag
        dispatch_en = 1'b1;
        #1;
        for (int i = 0; i < FL_SIZE; i++) exp_l[i] = (i < 30) ? PR_W'(10 + i) : '0;
        ckpt_vec = pack_exp();
        chk("ckpt_tail", tail_chkpt, 30);
        chk("ckpt_list", free_list_chkpt, ckpt_vec);
        for (int k = 0; k < 4; k++) tick();
        chk("post_pop4_head", T_new_out, 13);
        chk("post_pop4_tail", tail_chkpt, 26);

        // Restore with concurrent retire; dispatch squashed
        restore_en = 1'b1; free_list_restore = ckpt_vec; tail_restore = 6'd30;
        retire_en = 1'b1; T_old_in = 6'd9;
        #1;
        exp_l[30] = 6'd9;
        chk("restore_tail", tail_chkpt, 31);
        chk("restore_list", free_list_chkpt, pack_exp());
        tick();
        restore_en = 1'b0; retire_en = 1'b0; dispatch_en = 1'b0;
        #1;
        chk("restore_head", T_new_out, 10);
        chk("restore_tail_after", tail_chkpt, 31);
        chk("restore_list_after", free_list_chkpt, pack_exp());

        // Reset asserted mid-burst takes effect without a clock edge
        dispatch_en = 1'b1; retire_en = 1'b1; T_old_in = 6'd3;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("midrst_head", T_new_out, 32);
        chk("midrst_valid", T_new_valid, 1);
        chk("midrst_empty", empty, 0);
        chk("midrst_full", full, 1);

        // Restore while in reset is overridden
        restore_en = 1'b1; tail_restore = 6'd5; free_list_restore = '0;
        tick();
        chk("rst_restore_head", T_new_out, 32);
        chk("rst_restore_full", full, 1);
        restore_en = 1'b0; dispatch_en = 1'b0; retire_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < FL_SIZE; i++) exp_l[i] = PR_W'(32 + i);
        chk("rel_tail", tail_chkpt, 32);
        chk("rel_image", free_list_chkpt, pack_exp());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
